// File: rtl/vector_mem_responder.sv
// vector_mem_responder
//   Data-memory side of the load/store interface. Takes one scalar (1 beat)
//   or vector (LANES beats) request, plays it onto a single-port synchronous
//   RAM as N-bit beats, stalls the pipeline meanwhile and returns a one-cycle
//   response with V-bit read data and an address-limit error flag.
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   req_valid/we/vec         request strobe, store/load, vector/scalar
//   req_addr, req_wdata      byte address (bits [1:0] ignored), store data
//   stall                    hold the pipeline
//   rsp_valid/rdata/err      response pulse, load data, limit violation
//   ram_addr/we/wdata        RAM command (driven only in ISSUE)
//   ram_rdata                RAM read data, one cycle after ram_addr
module vector_mem_responder #(
    parameter int unsigned  N     = 32,
    parameter int unsigned  V     = 128,
    parameter logic [N-1:0] LIMIT = 32'h4AFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic         req_vec,
    input  logic [N-1:0] req_addr,
    input  logic [V-1:0] req_wdata,
    output logic         stall,
    output logic         rsp_valid,
    output logic [V-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [N-1:0] ram_addr,
    output logic         ram_we,
    output logic [N-1:0] ram_wdata,
    input  logic [N-1:0] ram_rdata
);
    localparam int unsigned LANES = V / N;
    localparam int unsigned BW    = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, ISSUE, LAST, RESP} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic           we_q, we_d;
    logic           vec_q, vec_d;
    logic [N-1:0]   base_q, base_d;
    logic [V-1:0]   wdata_q, wdata_d;
    logic [V-1:0]   acc_q, acc_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [V-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    logic [N-1:0]   req_base;
    logic [N:0]     span_end;
    logic           range_err;
    logic           last_beat;
    logic [BW-1:0]  prev_beat;

    // Range check uses one extra bit so a base near 2^N that wraps past the
    // top of the address space is caught as out of range.
    always_comb begin
        req_base  = req_addr & ~N'(3);
        span_end  = {1'b0, req_base} + (req_vec ? (N+1)'(4*LANES - 1) : (N+1)'(3));
        range_err = span_end > {1'b0, LIMIT};
        last_beat = beat_q == (vec_q ? BW'(LANES - 1) : BW'(0));
        prev_beat = beat_q - BW'(1);
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        we_d        = we_q;
        vec_d       = vec_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    vec_d   = req_vec;
                    base_d  = req_base;
                    wdata_d = req_wdata;
                    acc_d   = '0;
                    beat_d  = '0;
                    if (range_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // RAM data lags the address by one cycle, so beat k lands
                // the word requested by beat k-1.
                if (!we_q && beat_q != '0)
                    acc_d[prev_beat*N +: N] = ram_rdata;
                if (last_beat) begin
                    // beat_q is kept so LAST knows which lane is still owed.
                    if (we_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = LAST;
                    end
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            LAST: begin
                acc_d[beat_q*N +: N] = ram_rdata;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = acc_d;
                rsp_err_d   = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            we_q        <= 1'b0;
            vec_q       <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            we_q        <= we_d;
            vec_q       <= vec_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM command and stall are gated by reset so an aborted access stops
    // writing in the very cycle reset is seen.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        stall     = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE:  stall = req_valid;
                ISSUE: begin
                    stall     = 1'b1;
                    ram_we    = we_q;
                    ram_addr  = base_q + (N'(beat_q) << 2);
                    ram_wdata = wdata_q[beat_q*N +: N];
                end
                LAST:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_vector_mem_responder.sv
module tb_vector_mem_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_we, req_vec;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         stall, rsp_valid, rsp_err, ram_we;
    logic [127:0] rsp_rdata;
    logic [31:0]  ram_addr, ram_wdata, ram_rdata;

    vector_mem_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_vec(req_vec),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model: read-before-write, 1-cycle read latency.
    logic [31:0] mem [bit [31:0]];
    always @(posedge clk) begin
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    typedef struct {
        logic [127:0] rdata;
        logic         err;
        int           lat;
    } exp_t;
    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] addr_log  [0:15];
    logic [31:0] wd_log    [0:15];
    logic        we_log    [0:15];
    logic        stall_log [0:15];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request starting in the current (IDLE) cycle, logs the RAM
    // interface per cycle and checks the response against the scoreboard.
    // Returns at posedge+1 of the cycle after the response (an IDLE cycle).
    task automatic do_req(input logic we, input logic vec, input logic [31:0] addr,
                          input logic [127:0] wdata, input logic [127:0] exp_rd,
                          input logic exp_err, input int lat);
        exp_t e;
        bit   got;
        exp_q.push_back('{rdata: exp_rd, err: exp_err, lat: lat});
        req_valid = 1'b1; req_we = we; req_vec = vec; req_addr = addr; req_wdata = wdata;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            addr_log[c] = ram_addr; wd_log[c] = ram_wdata;
            we_log[c] = ram_we; stall_log[c] = stall;
            if (rsp_valid) begin
                got = 1;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 128'(rsp_err), 128'(e.err));
                chk("latency", 128'(c), 128'(e.lat));
                chk("stall_in_resp", 128'(stall), 128'h0);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        if (!got) begin
            chk("rsp_timeout", 128'h0, 128'h1);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        mem[32'h200] = 32'h11111111; mem[32'h204] = 32'h22222222;
        mem[32'h208] = 32'h33333333; mem[32'h20C] = 32'h44444444;
        for (int i = 0; i < 4; i++) mem[32'h300 + 4*i] = 32'h0;

        // Reset held with a request pending
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_vec = 1'b1;
        req_addr = 32'h100; req_wdata = {4{32'hA5A5A5A5}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 128'(stall), 128'h0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("rst_ram_we", 128'(ram_we), 128'h0);
        chk("rst_ram_addr", 128'(ram_addr), 128'h0);
        chk("rst_ram_wdata", 128'(ram_wdata), 128'h0);
        chk("rst_rsp_rdata", rsp_rdata, 128'h0);
        chk("rst_rsp_err", 128'(rsp_err), 128'h0);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;

        // Scalar store
        do_req(1'b1, 1'b0, 32'h100, 128'hDEADBEEF, 128'h0, 1'b0, 2);
        chk("ss_stall0", 128'(stall_log[0]), 128'h1);
        chk("ss_stall1", 128'(stall_log[1]), 128'h1);
        chk("ss_addr1", 128'(addr_log[1]), 128'h100);
        chk("ss_we1", 128'(we_log[1]), 128'h1);
        chk("ss_wdata1", 128'(wd_log[1]), 128'hDEADBEEF);
        chk("ss_addr_resp", 128'(addr_log[2]), 128'h0);
        chk("ss_mem", 128'(mem[32'h100]), 128'hDEADBEEF);

        // Vector load, misaligned low bits ignored
        do_req(1'b0, 1'b1, 32'h203, 128'h0,
               128'h44444444_33333333_22222222_11111111, 1'b0, 6);
        for (int b = 0; b < 4; b++) begin
            chk("vl_addr", 128'(addr_log[b+1]), 128'(32'h200 + 4*b));
            chk("vl_we", 128'(we_log[b+1]), 128'h0);
        end
        chk("vl_addr_last", 128'(addr_log[5]), 128'h0);
        chk("vl_stall_last", 128'(stall_log[5]), 128'h1);

        // Scalar load; then output must hold in IDLE
        do_req(1'b0, 1'b0, 32'h204, 128'h0, 128'h22222222, 1'b0, 3);
        @(negedge clk);
        chk("hold_rdata", rsp_rdata, 128'h22222222);
        chk("hold_rsp_valid", 128'(rsp_valid), 128'h0);
        @(posedge clk); #1;

        // Limit: last beat past LIMIT
        do_req(1'b1, 1'b1, 32'h4AFF8, {4{32'hBAD0BAD0}}, 128'h0, 1'b1, 1);
        chk("lim_we0", 128'(we_log[0]), 128'h0);
        chk("lim_we1", 128'(we_log[1]), 128'h0);
        chk("lim_nowrite", 128'(mem.exists(32'h4AFF8)), 128'h0);
        // Limit: last beat exactly at LIMIT
        do_req(1'b1, 1'b1, 32'h4AFF0,
               128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 128'h0, 1'b0, 5);
        do_req(1'b0, 1'b1, 32'h4AFF0, 128'h0,
               128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 1'b0, 6);
        do_req(1'b0, 1'b0, 32'h4B000, 128'h0, 128'h0, 1'b1, 1);
        // Wrap past 2^32 flagged
        do_req(1'b0, 1'b1, 32'hFFFFFFF8, 128'h0, 128'h0, 1'b1, 1);

        // Reset during cycle 2 of a vector store
        req_valid = 1'b1; req_we = 1'b1; req_vec = 1'b1; req_addr = 32'h300;
        req_wdata = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ram_we", 128'(ram_we), 128'h0);
        chk("abort_stall", 128'(stall), 128'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 128'(rsp_valid), 128'h0);
            @(posedge clk); #1;
        end
        chk("abort_beat0", 128'(mem[32'h300]), 128'h0A0A0A0A);
        chk("abort_beat1", 128'(mem[32'h304]), 128'h0);
        do_req(1'b0, 1'b1, 32'h300, 128'h0, 128'h0A0A0A0A, 1'b0, 6);

        chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
